// File: rtl/n1_demux_pkg.sv
// Shared definitions for the TDM receive demultiplexer.
// Holds the FSM state encoding and the slot-index width helper.
package n1_demux_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  // Slot index width; never below 1 so a 2-slot build still has a real counter bit.
  function automatic int unsigned sel_w(input int unsigned n_slots);
    return (n_slots <= 2) ? 1 : $clog2(n_slots);
  endfunction

endpackage

// File: rtl/n1_demux_tdm_if.sv
// Serial-in / frame-out bundle of the TDM demultiplexer.
// The slave modport is the demux side; the master modport is the link/consumer side.
interface n1_demux_tdm_if
  import n1_demux_pkg::*;
#(
  parameter int unsigned n     = 16,
  parameter int unsigned SEL_W = sel_w(n)
);

  logic             din;
  logic             din_valid;
  logic             sof;
  logic [n-1:0]     y;
  logic             y_valid;
  logic             y_ready;
  logic [SEL_W-1:0] slot;
  logic             frame_err;
  logic             overrun;

  modport master (
    output din,
    output din_valid,
    output sof,
    output y_ready,
    input  y,
    input  y_valid,
    input  slot,
    input  frame_err,
    input  overrun
  );

  modport slave (
    input  din,
    input  din_valid,
    input  sof,
    input  y_ready,
    output y,
    output y_valid,
    output slot,
    output frame_err,
    output overrun
  );

endinterface

// File: rtl/tdm_slot_cnt.sv
// Slot position counter: clears on frame done, loads 1 on start of frame,
// advances on each accepted mid-frame bit, and flags the final slot.
module tdm_slot_cnt #(
  parameter int unsigned N     = 16,
  parameter int unsigned SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_inc,
  output logic [SEL_W-1:0] o_slot,
  output logic             o_last_c
);

  logic [SEL_W-1:0] r_slot;

  // Clear wins over load, load over increment; the caller never increments past N-1.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_slot <= '0;
    end else if (i_load) begin
      r_slot <= SEL_W'(1);
    end else if (i_inc) begin
      r_slot <= r_slot + SEL_W'(1);
    end
  end

  assign o_slot   = r_slot;
  assign o_last_c = (r_slot == SEL_W'(N - 1));

endmodule

// File: rtl/n1_demux_tdm.sv
// Receive end of a slot-ordered N:1 TDM link: collects one bit per accepted
// cycle into a shadow word and publishes the full frame on a valid/ready output.
module n1_demux_tdm
  import n1_demux_pkg::*;
#(
  parameter int unsigned n     = 16,
  parameter int unsigned SEL_W = sel_w(n)
) (
  input logic           clk,
  input logic           rst,
  n1_demux_tdm_if.slave bus
);

  // The last slot bit goes straight into y, so the shadow only holds slots 0..n-2.
  localparam int unsigned SH_W = n - 1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [SH_W-1:0]  r_shadow;
  logic [SH_W-1:0]  w_shadow_nxt;
  logic [SH_W-1:0]  w_wr_en;
  logic [n-1:0]     r_y;
  logic [n-1:0]     w_y_nxt;
  logic             r_y_valid;
  logic             w_y_valid_nxt;
  logic             r_frame_err;
  logic             w_frame_err_nxt;
  logic             r_overrun;
  logic             w_overrun_nxt;

  logic             w_start;
  logic             w_inc;
  logic             w_done;
  logic             w_in_fill;
  logic [SEL_W-1:0] w_slot;
  logic             w_last;

  assign w_in_fill = (r_state == ST_FILL);
  assign w_start   = bus.din_valid & bus.sof;
  assign w_inc     = bus.din_valid & ~bus.sof & w_in_fill & ~w_last;
  assign w_done    = bus.din_valid & ~bus.sof & w_in_fill & w_last;

  tdm_slot_cnt #(
    .N     (n),
    .SEL_W (SEL_W)
  ) u_slot_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_done),
    .i_load   (w_start),
    .i_inc    (w_inc),
    .o_slot   (w_slot),
    .o_last_c (w_last)
  );

  // One-hot shadow write enable from the current slot index.
  always_comb begin
    w_wr_en = '0;
    for (int unsigned k = 0; k < SH_W; k++) begin
      w_wr_en[k] = (w_slot == SEL_W'(k));
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_shadow_nxt    = r_shadow;
    w_y_nxt         = r_y;
    w_y_valid_nxt   = r_y_valid;
    w_frame_err_nxt = 1'b0;
    w_overrun_nxt   = 1'b0;

    if (r_y_valid && bus.y_ready) begin
      w_y_valid_nxt = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_shadow_nxt    = '0;
          w_shadow_nxt[0] = bus.din;
          w_state_nxt     = ST_FILL;
        end
      end
      ST_FILL: begin
        if (w_start) begin
          // Resync: drop the partial frame and restart at slot 0 with this bit.
          w_frame_err_nxt = 1'b1;
          w_shadow_nxt    = '0;
          w_shadow_nxt[0] = bus.din;
        end else if (w_done) begin
          w_y_nxt       = {bus.din, r_shadow};
          w_y_valid_nxt = 1'b1;
          w_overrun_nxt = r_y_valid & ~bus.y_ready;
          w_state_nxt   = ST_IDLE;
        end else if (w_inc) begin
          w_shadow_nxt = (r_shadow & ~w_wr_en) | (w_wr_en & {SH_W{bus.din}});
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_shadow    <= '0;
      r_y         <= '0;
      r_y_valid   <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shadow    <= w_shadow_nxt;
      r_y         <= w_y_nxt;
      r_y_valid   <= w_y_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  assign bus.y         = r_y;
  assign bus.y_valid   = r_y_valid;
  assign bus.slot      = w_slot;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_n1_demux_tdm.sv
// Bench for n1_demux_tdm: directed frames plus random traffic against a
// queue-based frame model, compared on every falling edge.
module tb_n1_demux_tdm;

  localparam int unsigned N = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  n1_demux_tdm_if #(.n(N)) bus ();

  n1_demux_tdm #(.n(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_ferr = 0;
  int cnt_ovr = 0;
  int cnt_yv = 0;
  bit chk_en = 1'b0;

  // Model: bits of the frame in progress (empty when idle), plus the published frame.
  bit           q[$];
  logic [N-1:0] m_y;
  bit           m_v;
  bit           m_ferr;
  bit           m_ovr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic [N-1:0] w;
    bit done;
    done   = 1'b0;
    w      = '0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    if (rst) begin
      q.delete();
      m_y = '0;
      m_v = 1'b0;
    end else begin
      if (bus.din_valid && bus.sof) begin
        m_ferr = (q.size() != 0);
        q.delete();
        q.push_back(bus.din);
      end else if (bus.din_valid && q.size() != 0) begin
        q.push_back(bus.din);
        if (q.size() == N) begin
          done = 1'b1;
          for (int k = 0; k < N; k++) w[k] = q[k];
          q.delete();
        end
      end
      if (done) begin
        m_ovr = m_v && !bus.y_ready;
        m_y   = w;
        m_v   = 1'b1;
      end else if (m_v && bus.y_ready) begin
        m_v = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("y",         32'(bus.y),         32'(m_y));
      chk("y_valid",   32'(bus.y_valid),   32'(m_v));
      chk("slot",      32'(bus.slot),      32'(q.size()));
      chk("frame_err", 32'(bus.frame_err), 32'(m_ferr));
      chk("overrun",   32'(bus.overrun),   32'(m_ovr));
      if (bus.frame_err) cnt_ferr++;
      if (bus.overrun)   cnt_ovr++;
      if (bus.y_valid)   cnt_yv++;
    end
  end

  task automatic step(input logic r, input logic d, input logic dv, input logic s, input logic rdy);
    rst           = r;
    bus.din       = d;
    bus.din_valid = dv;
    bus.sof       = s;
    bus.y_ready   = rdy;
    @(negedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [N-1:0] w, input bit gaps, input logic rdy);
    for (int k = 0; k < int'(N); k++) begin
      if (gaps && k > 0) step(1'b0, 1'($urandom), 1'b0, 1'($urandom), rdy);
      step(1'b0, w[k], 1'b1, (k == 0), rdy);
    end
  endtask

  initial begin
    int f0;
    int o0;
    int v0;
    rst           = 1'b1;
    bus.din       = 1'b0;
    bus.din_valid = 1'b0;
    bus.sof       = 1'b0;
    bus.y_ready   = 1'b0;
    @(negedge clk);
    #1;
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk_en = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst_y",       32'(bus.y),       32'h0);
    chk("rst_y_valid", 32'(bus.y_valid), 32'h0);
    chk("rst_slot",    32'(bus.slot),    32'h0);

    // 1: single frame, consumer stalled
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("s1_idle_ignore_slot", 32'(bus.slot), 32'h0);
    send_frame(16'hA5C3, 1'b0, 1'b0);
    chk("s1_y",       32'(bus.y),       32'hA5C3);
    chk("s1_model_y", 32'(m_y),         32'hA5C3);
    chk("s1_y_valid", 32'(bus.y_valid), 32'h1);

    // 2: two frames into a stalled consumer
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    o0 = cnt_ovr;
    send_frame(16'h1234, 1'b0, 1'b0);
    chk("s2_first_y", 32'(bus.y), 32'h1234);
    send_frame(16'hFFFF, 1'b0, 1'b0);
    chk("s2_y",       32'(bus.y),       32'hFFFF);
    chk("s2_y_valid", 32'(bus.y_valid), 32'h1);
    chk("s2_overrun_count", 32'(cnt_ovr - o0), 32'h1);

    // 3: gaps between accepted bits
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    o0 = cnt_ovr;
    send_frame(16'h00FF, 1'b1, 1'b0);
    chk("s3_y",       32'(bus.y),       32'h00FF);
    chk("s3_model_y", 32'(m_y),         32'h00FF);
    chk("s3_no_overrun", 32'(cnt_ovr - o0), 32'h0);

    // 4: sof arriving at slot 7
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    f0 = cnt_ferr;
    for (int k = 0; k < 7; k++) step(1'b0, 1'($urandom), 1'b1, (k == 0), 1'b0);
    chk("s4_slot7", 32'(bus.slot), 32'h7);
    send_frame(16'h8001, 1'b0, 1'b0);
    chk("s4_y",         32'(bus.y),        32'h8001);
    chk("s4_ferr_count", 32'(cnt_ferr - f0), 32'h1);

    // 5: reset mid-frame with a pending frame
    for (int k = 0; k < 9; k++) step(1'b0, 1'($urandom), 1'b1, (k == 0), 1'b0);
    chk("s5_pre_slot",    32'(bus.slot),    32'h9);
    chk("s5_pre_y_valid", 32'(bus.y_valid), 32'h1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("s5_y_valid", 32'(bus.y_valid), 32'h0);
    chk("s5_slot",    32'(bus.slot),    32'h0);
    chk("s5_y",       32'(bus.y),       32'h0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'($urandom), 1'b1, 1'b0, 1'b0);
    chk("s5_ignored_slot",    32'(bus.slot),    32'h0);
    chk("s5_ignored_y_valid", 32'(bus.y_valid), 32'h0);

    // 6: back-to-back frames, consumer always ready
    f0 = cnt_ferr;
    o0 = cnt_ovr;
    v0 = cnt_yv;
    send_frame(16'hBEEF, 1'b0, 1'b1);
    chk("s6_first_y", 32'(bus.y), 32'hBEEF);
    send_frame(16'hCAFE, 1'b0, 1'b1);
    chk("s6_y", 32'(bus.y), 32'hCAFE);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("s6_handshakes", 32'(cnt_yv - v0),   32'h2);
    chk("s6_no_ferr",    32'(cnt_ferr - f0), 32'h0);
    chk("s6_no_ovr",     32'(cnt_ovr - o0),  32'h0);

    // Random traffic: clean frames mixed with noisy stretches
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        send_frame(N'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        for (int k = 0; k < 12; k++) begin
          step(($urandom_range(0, 99) == 0), 1'($urandom), ($urandom_range(0, 99) < 75),
               ($urandom_range(0, 99) < 5), 1'($urandom));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
